id_hazard_scoreboard: RTL and testbench

//  Scoreboard and stall controller that sequences the instruction-decode stage.

---
 rtl/id_hazard_scoreboard_if.sv | 41 ++++
 rtl/id_hazard_scoreboard.sv | 129 ++++++++++++
 tb/tb_id_hazard_scoreboard.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/id_hazard_scoreboard_if.sv
// Decode/execute/writeback handshake bundle for the ID hazard scoreboard.
// The master side (decode, execute, writeback) drives the instruction fields
// and retire events. The slave side (the scoreboard) returns the issue/stall
// decision and the tracked state.
interface id_hazard_scoreboard_if #(
    parameter int NREGS        = 32,
    parameter int MAX_INFLIGHT = 4
);
    // Decode-side instruction description
    logic                                    id_valid;
    logic [4:0]                              id_rs1;
    logic [4:0]                              id_rs2;
    logic                                    id_uses_rs1;
    logic                                    id_uses_rs2;
    logic [4:0]                              id_rd;
    logic                                    id_writes_rd;

    // Downstream acceptance and writeback retire
    logic                                    ex_ready;
    logic                                    wb_valid;
    logic [4:0]                              wb_rd;

    // Scoreboard decisions and visible state
    logic                                    id_issue;
    logic                                    id_stall;
    logic [NREGS-1:0]                        busy_mask;
    logic [$clog2(MAX_INFLIGHT+1)-1:0]       inflight;
    logic                                    sb_err;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output id_rd, id_writes_rd, ex_ready, wb_valid, wb_rd,
        input  id_issue, id_stall, busy_mask, inflight, sb_err
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  id_rd, id_writes_rd, ex_ready, wb_valid, wb_rd,
        output id_issue, id_stall, busy_mask, inflight, sb_err
    );
endinterface

// File: rtl/id_hazard_scoreboard.sv
// ID-stage hazard scoreboard and stall controller.
// Keeps a small pending-write counter per architectural register, counts the
// total number of tracked writes in flight, and decides combinationally each
// cycle whether the decoded instruction issues or stalls.
// Optional feature macro: SCOREBOARD_BYPASS_EN -- lets a same-cycle writeback
// retire clear a RAW hazard and free an in-flight slot for the current issue.
module id_hazard_scoreboard #(
    parameter int NREGS        = 32,
    parameter int CNT_W        = 2,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    id_hazard_scoreboard_if.slave sb
);

    localparam int              IFW     = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [IFW-1:0]   IF_MAX  = IFW'(MAX_INFLIGHT);

    logic [CNT_W-1:0] r_cnt [NREGS];
    logic [IFW-1:0]   r_inflight;
    logic             r_sb_err;

    logic [NREGS-1:0] w_busy;
    logic             w_rs1_busy;
    logic             w_rs2_busy;
    logic             w_rs1_haz;
    logic             w_rs2_haz;
    logic             w_hazard_raw;
    logic             w_hazard_waw;
    logic             w_full;
    logic             w_retire_req;
    logic             w_retire_hit;
    logic             w_retire_err;
    logic             w_track_req;
    logic             w_issue;
    logic             w_track;

    // Busy vector derived purely from the registered counters
    always_comb begin
        w_busy = '0;
        for (int n = 0; n < NREGS; n++) begin
            w_busy[n] = (r_cnt[n] != '0);
        end
    end

    // Hazard, capacity and retire classification for the current cycle
    always_comb begin
        w_rs1_busy   = sb.id_uses_rs1 && (sb.id_rs1 != 5'd0) && w_busy[sb.id_rs1];
        w_rs2_busy   = sb.id_uses_rs2 && (sb.id_rs2 != 5'd0) && w_busy[sb.id_rs2];
        w_retire_req = sb.wb_valid && (sb.wb_rd != 5'd0);
        w_retire_hit = w_retire_req && w_busy[sb.wb_rd];
        w_retire_err = w_retire_req && !w_busy[sb.wb_rd];
        w_track_req  = sb.id_writes_rd && (sb.id_rd != 5'd0);
        w_hazard_waw = w_track_req && (r_cnt[sb.id_rd] == CNT_MAX);
`ifdef SCOREBOARD_BYPASS_EN
        w_rs1_haz    = w_rs1_busy && !(w_retire_hit && (r_cnt[sb.wb_rd] == CNT_W'(1))
                                       && (sb.wb_rd == sb.id_rs1));
        w_rs2_haz    = w_rs2_busy && !(w_retire_hit && (r_cnt[sb.wb_rd] == CNT_W'(1))
                                       && (sb.wb_rd == sb.id_rs2));
        w_full       = w_track_req && ((r_inflight - IFW'(w_retire_hit)) == IF_MAX);
`else
        w_rs1_haz    = w_rs1_busy;
        w_rs2_haz    = w_rs2_busy;
        w_full       = w_track_req && (r_inflight == IF_MAX);
`endif
        w_hazard_raw = w_rs1_haz || w_rs2_haz;
    end

    // Issue decision; nothing issues while reset is held
    always_comb begin
        w_issue = !reset && sb.id_valid && sb.ex_ready
                  && !w_hazard_raw && !w_hazard_waw && !w_full;
        w_track = w_issue && w_track_req;
    end

    // Per-register pending-write counters; r0 is pinned at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < NREGS; n++) begin
                r_cnt[n] <= '0;
            end
        end else begin
            r_cnt[0] <= '0;
            for (int n = 1; n < NREGS; n++) begin
                if (w_track && (sb.id_rd == 5'(n)) &&
                    !(w_retire_hit && (sb.wb_rd == 5'(n)))) begin
                    r_cnt[n] <= r_cnt[n] + CNT_W'(1);
                end else if (w_retire_hit && (sb.wb_rd == 5'(n)) &&
                             !(w_track && (sb.id_rd == 5'(n)))) begin
                    r_cnt[n] <= r_cnt[n] - CNT_W'(1);
                end
            end
        end
    end

    // Global in-flight count: one up per tracked issue, one down per retire
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inflight <= '0;
        end else begin
            case ({w_track, w_retire_hit})
                2'b10:   r_inflight <= r_inflight + IFW'(1);
                2'b01:   r_inflight <= r_inflight - IFW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Sticky error for a retire that has no matching pending write
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sb_err <= 1'b0;
        end else if (w_retire_err) begin
            r_sb_err <= 1'b1;
        end
    end

    // Drive the handshake outputs from the decision logic and registered state
    always_comb begin
        sb.id_issue  = w_issue;
        sb.id_stall  = !reset && sb.id_valid && !w_issue;
        sb.busy_mask = w_busy;
        sb.inflight  = r_inflight;
        sb.sb_err    = r_sb_err;
    end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Self-checking bench for id_hazard_scoreboard: a table of per-cycle vectors
// whose expected outputs are queued when driven and popped when sampled.
// Expectations that depend on SCOREBOARD_BYPASS_EN follow the same macro.
module tb_id_hazard_scoreboard;

`ifdef SCOREBOARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic        v;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  rd;
        logic        wr;
        logic        exr;
        logic        wbv;
        logic [4:0]  wbrd;
        logic        eIssue;
        logic        eStall;
        logic [31:0] eMask;
        logic [2:0]  eInfl;
        logic        eErr;
    } vec_t;

    logic clk;
    logic reset;
    vec_t vecs[$];
    vec_t expQ[$];
    int   rowIdx;
    int   passCount;
    int   totalCount;

    id_hazard_scoreboard_if #(.NREGS(32), .MAX_INFLIGHT(4)) busIf ();

    id_hazard_scoreboard #(.NREGS(32), .CNT_W(2), .MAX_INFLIGHT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (busIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void addRow(
        input logic rst, input logic v,
        input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
        input logic [4:0] rd, input logic wr, input logic exr,
        input logic wbv, input logic [4:0] wbrd,
        input logic eIssue, input logic eStall, input logic [31:0] eMask,
        input logic [2:0] eInfl, input logic eErr);
        vec_t r;
        r.rst = rst; r.v = v; r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2;
        r.rd = rd; r.wr = wr; r.exr = exr; r.wbv = wbv; r.wbrd = wbrd;
        r.eIssue = eIssue; r.eStall = eStall; r.eMask = eMask;
        r.eInfl = eInfl; r.eErr = eErr;
        vecs.push_back(r);
    endfunction

    task automatic applyStimulus(input vec_t r);
        reset              = r.rst;
        busIf.id_valid     = r.v;
        busIf.id_rs1       = r.rs1;
        busIf.id_uses_rs1  = r.u1;
        busIf.id_rs2       = r.rs2;
        busIf.id_uses_rs2  = r.u2;
        busIf.id_rd        = r.rd;
        busIf.id_writes_rd = r.wr;
        busIf.ex_ready     = r.exr;
        busIf.wb_valid     = r.wbv;
        busIf.wb_rd        = r.wbrd;
        expQ.push_back(r);
    endtask

    task automatic compareField(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        totalCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s row %0d: got %h expected %h", name, rowIdx, act, exp);
        end
    endtask

    task automatic checkOutput();
        vec_t e;
        if (expQ.size() == 0) begin
            totalCount++;
            $display("[TB] FAIL queue row %0d: got empty expected entry", rowIdx);
        end else begin
            e = expQ.pop_front();
            compareField("id_issue",  32'(busIf.id_issue),  32'(e.eIssue));
            compareField("id_stall",  32'(busIf.id_stall),  32'(e.eStall));
            compareField("busy_mask", busIf.busy_mask,      e.eMask);
            compareField("inflight",  32'(busIf.inflight),  32'(e.eInfl));
            compareField("sb_err",    32'(busIf.sb_err),    32'(e.eErr));
        end
    endtask

    initial begin
        passCount  = 0;
        totalCount = 0;
        rowIdx     = 0;
        reset      = 1'b1;
        busIf.id_valid = 1'b0; busIf.id_rs1 = '0; busIf.id_rs2 = '0;
        busIf.id_uses_rs1 = 1'b0; busIf.id_uses_rs2 = 1'b0; busIf.id_rd = '0;
        busIf.id_writes_rd = 1'b0; busIf.ex_ready = 1'b0;
        busIf.wb_valid = 1'b0; busIf.wb_rd = '0;

        //     rst v rs1 u1 rs2 u2 rd wr ex wbv wbrd | iss stl mask inf err
        // reset holds off issue; then a clean RAW-free issue
        addRow(1,1, 3,1, 4,1, 0,0, 1, 0,0,  0,0,32'h00,0,0);
        addRow(0,1, 3,1, 4,1, 0,0, 1, 0,0,  1,0,32'h00,0,0);
        // writer to r5, dependent consumer stalls until retire, one bubble
        addRow(0,1, 0,0, 0,0, 5,1, 1, 0,0,  1,0,32'h00,0,0);
        addRow(0,1, 5,1, 0,0, 0,0, 1, 0,0,  0,1,32'h20,1,0);
        addRow(0,1, 5,1, 0,0, 0,0, 0, 1,5,  0,1,32'h20,1,0);
        addRow(0,1, 5,1, 0,0, 0,0, 1, 0,0,  1,0,32'h00,0,0);
        // r0 writes are not tracked, r0 reads never hazard
        addRow(0,1, 0,0, 0,0, 0,1, 1, 0,0,  1,0,32'h00,0,0);
        addRow(0,1, 0,1, 0,1, 0,0, 1, 0,0,  1,0,32'h00,0,0);
        // fill all four in-flight slots, fifth writer stalls on full
        addRow(0,1, 0,0, 0,0, 1,1, 1, 0,0,  1,0,32'h00,0,0);
        addRow(0,1, 0,0, 0,0, 2,1, 1, 0,0,  1,0,32'h02,1,0);
        addRow(0,1, 0,0, 0,0, 3,1, 1, 0,0,  1,0,32'h06,2,0);
        addRow(0,1, 0,0, 0,0, 4,1, 1, 0,0,  1,0,32'h0E,3,0);
        addRow(0,1, 0,0, 0,0, 6,1, 1, 0,0,  0,1,32'h1E,4,0);
        addRow(0,0, 0,0, 0,0, 0,0, 1, 1,1,  0,0,32'h1E,4,0);
        addRow(0,1, 0,0, 0,0, 6,1, 1, 0,0,  1,0,32'h1C,3,0);
        addRow(0,0, 0,0, 0,0, 0,0, 1, 1,2,  0,0,32'h5C,4,0);
        addRow(0,0, 0,0, 0,0, 0,0, 1, 1,3,  0,0,32'h58,3,0);
        addRow(0,0, 0,0, 0,0, 0,0, 1, 1,4,  0,0,32'h50,2,0);
        addRow(0,0, 0,0, 0,0, 0,0, 1, 1,6,  0,0,32'h40,1,0);
        // three writes to r7 saturate its counter, fourth stalls on WAW
        addRow(0,1, 0,0, 0,0, 7,1, 1, 0,0,  1,0,32'h00,0,0);
        addRow(0,1, 0,0, 0,0, 7,1, 1, 0,0,  1,0,32'h80,1,0);
        addRow(0,1, 0,0, 0,0, 7,1, 1, 0,0,  1,0,32'h80,2,0);
        addRow(0,1, 0,0, 0,0, 7,1, 1, 0,0,  0,1,32'h80,3,0);
        addRow(0,1, 0,0, 0,0, 7,1, 1, 1,7,  0,1,32'h80,3,0);
        addRow(0,1, 0,0, 0,0, 7,1, 1, 0,0,  1,0,32'h80,2,0);
        addRow(0,0, 0,0, 0,0, 0,0, 1, 0,0,  0,0,32'h80,3,0);
        addRow(0,1, 0,0, 0,0, 7,1, 1, 0,0,  0,1,32'h80,3,0);
        // r0 retire is silent; retire of idle r9 sets the sticky error
        addRow(0,0, 0,0, 0,0, 0,0, 1, 1,0,  0,0,32'h80,3,0);
        addRow(0,0, 0,0, 0,0, 0,0, 1, 1,9,  0,0,32'h80,3,0);
        addRow(0,0, 0,0, 0,0, 0,0, 1, 0,0,  0,0,32'h80,3,1);
        addRow(0,0, 0,0, 0,0, 0,0, 1, 1,7,  0,0,32'h80,3,1);
        // same-register issue+retire nets zero; different registers both apply
        addRow(0,1, 0,0, 0,0, 2,1, 1, 0,0,  1,0,32'h80,2,1);
        addRow(0,1, 0,0, 0,0, 2,1, 1, 1,2,  1,0,32'h84,3,1);
        addRow(0,1, 0,0, 0,0, 3,1, 1, 1,7,  1,0,32'h84,3,1);
        addRow(0,0, 0,0, 0,0, 0,0, 1, 0,0,  0,0,32'h8C,3,1);
        addRow(0,0, 0,0, 0,0, 0,0, 1, 1,2,  0,0,32'h8C,3,1);
        addRow(0,0, 0,0, 0,0, 0,0, 1, 0,0,  0,0,32'h88,2,1);
        // mid-stream reset discards all pending state and the error flag
        addRow(1,1, 3,1, 0,0, 0,0, 1, 0,0,  0,0,32'h88,2,1);
        addRow(0,0, 0,0, 0,0, 0,0, 1, 0,0,  0,0,32'h00,0,0);
        // same-cycle retire against a RAW consumer
        addRow(0,1, 0,0, 0,0, 5,1, 1, 0,0,  1,0,32'h00,0,0);
        addRow(0,1, 5,1, 0,0, 0,0, 1, 1,5,  BYP,!BYP,32'h20,1,0);
        addRow(0,1, 5,1, 0,0, 0,0, 1, 0,0,  1,0,32'h00,0,0);
        // same-cycle retire against a full in-flight window
        addRow(0,1, 0,0, 0,0, 1,1, 1, 0,0,  1,0,32'h00,0,0);
        addRow(0,1, 0,0, 0,0, 2,1, 1, 0,0,  1,0,32'h02,1,0);
        addRow(0,1, 0,0, 0,0, 3,1, 1, 0,0,  1,0,32'h06,2,0);
        addRow(0,1, 0,0, 0,0, 4,1, 1, 0,0,  1,0,32'h0E,3,0);
        addRow(0,1, 0,0, 0,0, 6,1, 1, 1,1,  BYP,!BYP,32'h1E,4,0);
        addRow(0,0, 0,0, 0,0, 0,0, 1, 0,0,  0,0,(BYP ? 32'h5C : 32'h1C),(BYP ? 3'd4 : 3'd3),0);

        repeat (2) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            rowIdx = i;
            applyStimulus(vecs[i]);
            #3;
            checkOutput();
        end

        $display("[TB] %0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
